// File: rtl/register_file_pkg.sv
// Shared MIPS register-file constants: well-known register indices and the
// architectural defaults used by the register file and its bench.
package register_file_pkg;

    localparam int          N_REGS           = 32;
    localparam int          IDX_BITS         = 5;
    localparam int          DEFAULT_N_BITS   = 32;

    localparam logic [IDX_BITS-1:0] REG_ZERO = 5'd0;
    localparam logic [IDX_BITS-1:0] REG_SP   = 5'd29;
    localparam logic [IDX_BITS-1:0] REG_RA   = 5'd31;

    localparam logic [DEFAULT_N_BITS-1:0] SP_RESET_DEFAULT = 32'h7FFF_EFFC;

    // $zero is never stored; any lookup of index 0 must resolve to 0.
    function automatic logic is_zero_reg(input logic [IDX_BITS-1:0] idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/register_file_reg.sv
// Single N_BITS storage register with load enable and an asynchronous,
// active-high reset to a parameterised value.
module register_n #(
    parameter int              N_BITS    = 32,
    parameter logic [N_BITS-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [N_BITS-1:0] i_d,
    output logic [N_BITS-1:0] o_q
);

    logic [N_BITS-1:0] r_q;

    // Reset dominates a coincident load, so a write racing reset is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// 32 x N_BITS MIPS general-purpose register file: two combinational read
// ports, one synchronous write port, hardwired $zero, optional write bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int                N_BITS   = DEFAULT_N_BITS,
    parameter logic [N_BITS-1:0] SP_RESET = N_BITS'(SP_RESET_DEFAULT),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite,
    input  logic [IDX_BITS-1:0] WriteRegister,
    input  logic [N_BITS-1:0]   WriteData,
    input  logic [IDX_BITS-1:0] ReadRegister1,
    input  logic [IDX_BITS-1:0] ReadRegister2,
    output logic [N_BITS-1:0]   ReadData1,
    output logic [N_BITS-1:0]   ReadData2
);

    logic [N_BITS-1:0] w_regs [N_REGS];
    logic [N_REGS-1:1] w_wr_en;
    logic              w_bypass1;
    logic              w_bypass2;

    assign w_regs[0] = '0;

    // One-hot write decode; index 0 has no storage so its write falls away.
    genvar gi;
    generate
        for (gi = 1; gi < N_REGS; gi++) begin : g_reg
            localparam logic [N_BITS-1:0] RST_V =
                (gi == int'(REG_SP)) ? SP_RESET : '0;

            assign w_wr_en[gi] = RegWrite && (WriteRegister == IDX_BITS'(gi));

            register_n #(
                .N_BITS   (N_BITS),
                .RESET_VAL(RST_V)
            ) u_reg (
                .clk (clk),
                .rst (reset),
                .i_en(w_wr_en[gi]),
                .i_d (WriteData),
                .o_q (w_regs[gi])
            );
        end
    endgenerate

    // While reset is held the stored reset values are authoritative.
    assign w_bypass1 = BYPASS && !reset && RegWrite &&
                       !is_zero_reg(ReadRegister1) &&
                       (WriteRegister == ReadRegister1);
    assign w_bypass2 = BYPASS && !reset && RegWrite &&
                       !is_zero_reg(ReadRegister2) &&
                       (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1 = w_regs[ReadRegister1];
        ReadData2 = w_regs[ReadRegister2];
        if (w_bypass1) begin
            ReadData1 = WriteData;
        end
        if (w_bypass2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one bypassing and one non-bypassing
// instance share stimulus; expected values are hand-computed constants.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1, ReadData2;
    logic [31:0] nb_ReadData1, nb_ReadData2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 if (clk_en) clk = ~clk;

    register_file #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    register_file #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(nb_ReadData1), .ReadData2(nb_ReadData2)
    );

    task automatic check_vec(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("vec %0d %s: %08h ok", n_vec, tag, got);
        end
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = idx;
        WriteData     = data;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0;
        WriteData = '0; ReadRegister1 = 5'd29; ReadRegister2 = 5'd8;
        #1;
        // Reset values with the clock stopped.
        check_vec("rst_sp_p1", ReadData1, 32'h7FFF_EFFC);
        check_vec("rst_r8_p2", ReadData2, 32'h0);
        for (int i = 1; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i + 1);
            #1;
            check_vec($sformatf("rst_p1_r%0d", i), ReadData1,
                      (i == 29) ? 32'h7FFF_EFFC : 32'h0);
        end
        ReadRegister2 = 5'd29;
        #1;
        check_vec("rst_sp_p2", ReadData2, 32'h7FFF_EFFC);

        clk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Basic write to register 8.
        write_reg(5'd8, 32'hDEAD_BEEF);
        ReadRegister1 = 5'd8; ReadRegister2 = 5'd9;
        #1;
        check_vec("wr8_p1", ReadData1, 32'hDEAD_BEEF);
        check_vec("wr8_p2_r9", ReadData2, 32'h0);
        check_vec("wr8_nb_p1", nb_ReadData1, 32'hDEAD_BEEF);

        // Writes to $zero are discarded, bypass included.
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'h1234_5678;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        #1;
        check_vec("zero_pre_p1", ReadData1, 32'h0);
        check_vec("zero_pre_p2", ReadData2, 32'h0);
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        check_vec("zero_post_p1", ReadData1, 32'h0);
        check_vec("zero_post_p2", ReadData2, 32'h0);

        // Bypass vs. no bypass before the edge, both stored after.
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd17; WriteData = 32'h0000_00A5;
        ReadRegister2 = 5'd17; ReadRegister1 = 5'd8;
        #1;
        check_vec("byp_p2", ReadData2, 32'h0000_00A5);
        check_vec("nobyp_p2", nb_ReadData2, 32'h0);
        check_vec("byp_other_p1", ReadData1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        check_vec("byp_post_p2", ReadData2, 32'h0000_00A5);
        check_vec("nobyp_post_p2", nb_ReadData2, 32'h0000_00A5);

        // ALU operands: 7 - 3 = 4, nonzero.
        write_reg(5'd5, 32'd7);
        write_reg(5'd6, 32'd3);
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
        #1;
        check_vec("alu_a", ReadData1, 32'd7);
        check_vec("alu_b", ReadData2, 32'd3);
        check_vec("alu_sub", ReadData1 - ReadData2, 32'd4);
        check_vec("alu_zero", 32'(ReadData1 == ReadData2), 32'd0);
        ReadRegister2 = 5'd5;
        #1;
        check_vec("same_p1", ReadData1, 32'd7);
        check_vec("same_p2", ReadData2, 32'd7);

        // Asynchronous reset between edges, coincident write dropped.
        write_reg(5'd29, 32'h1000_0000);
        write_reg(5'd31, 32'hFFFF_FFFF);
        ReadRegister1 = 5'd29; ReadRegister2 = 5'd31;
        #1;
        check_vec("pre_rst_sp", ReadData1, 32'h1000_0000);
        check_vec("pre_rst_ra", ReadData2, 32'hFFFF_FFFF);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_vec("arst_sp", ReadData1, 32'h7FFF_EFFC);
        check_vec("arst_ra", ReadData2, 32'h0);
        RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'h0000_0055;
        ReadRegister1 = 5'd8;
        #1;
        check_vec("rst_no_byp", ReadData1, 32'h0);
        @(posedge clk); #1;
        check_vec("rst_wr_drop", ReadData1, 32'h0);
        @(negedge clk);
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        check_vec("rel_r8", ReadData1, 32'h0);
        check_vec("rel_nb_r8", nb_ReadData1, 32'h0);

        // First write after release lands on the next rising edge.
        write_reg(5'd10, 32'h0000_0ABC);
        ReadRegister1 = 5'd10; ReadRegister2 = 5'd29;
        #1;
        check_vec("rel_wr10", ReadData1, 32'h0000_0ABC);
        check_vec("rel_sp", ReadData2, 32'h7FFF_EFFC);

        // RegWrite low leaves storage untouched.
        @(negedge clk);
        RegWrite = 1'b0; WriteRegister = 5'd10; WriteData = 32'hFFFF_0000;
        @(posedge clk); #1;
        check_vec("nowr_r10", ReadData1, 32'h0000_0ABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the ALU. Its ReadData1 drives the ALU A operand; its ReadData2 drives the B operand (via the ALUSrc mux).
- Two asynchronous read ports and one synchronous write port.
- $zero is hardwired to 0; $sp has a configurable reset value; optional write-to-read bypass.

Parameters:
- N_BITS, 32, data width of each register.
- SP_RESET, 32'h7FFF_EFFC, value loaded into register 29 ($sp) on reset.
- BYPASS, 1, 1 = a read of the register being written this cycle returns WriteData; 0 = the read returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- RegWrite  input  1  write enable, sampled at posedge clk.
- WriteRegister  input  5  destination register index.
- WriteData  input  N_BITS  data to write.
- ReadRegister1  input  5  read port 1 index (rs).
- ReadRegister2  input  5  read port 2 index (rt).
- ReadData1  output  N_BITS  read port 1 data, feeds ALU A.
- ReadData2  output  N_BITS  read port 2 data, feeds the ALU B path.

Behaviour:
- Reset (asynchronous, active-high): this is decided.
  - While reset is high, registers 1..28 and 30..31 = 0 and register 29 = SP_RESET, independent of clk.
  - Reset asserted mid-write wins over the write; the write is lost.
  - Release is synchronous to the next posedge; the first write takes effect at the first rising edge with reset low.
- Write:
  - At posedge clk with RegWrite = 1 and WriteRegister != 0, reg[WriteRegister] <= WriteData.
  - Writes are visible in storage one cycle later (latency 1).
  - RegWrite = 0 leaves all registers unchanged.
- Register 0:
  - Not stored; always reads 0.
  - Writes to index 0 are silently discarded, even with RegWrite = 1.
- Read:
  - Purely combinational from the index inputs; zero-cycle latency.
  - ReadDataX = 0 if ReadRegisterX == 0.
  - Otherwise, with BYPASS = 1 and RegWrite = 1 and WriteRegister == ReadRegisterX (nonzero), ReadDataX = WriteData.
  - Otherwise ReadDataX = reg[ReadRegisterX].
- Both ports may read the same index simultaneously; both return the identical value.
- Bypass is suppressed while reset is high: reads return the reset values.
- No X propagation: every index 0..31 is valid, so there is no default-case garbage.
- Outputs during reset: the read value of the addressed register, i.e. 0, or SP_RESET if an index is 29.

Decomposition:
- Shared constants (MIPS register-index package or include):
  - REG_ZERO = 5'd0, REG_SP = 5'd29, REG_RA = 5'd31.
  - N_REGS = 32, default SP_RESET.
- Natural sub-module: register_n, an N_BITS register with enable, asynchronous active-high reset and a parameterised reset value.
  - Instantiated 31 times via generate (indices 1..31), with a 5-to-32 one-hot write decoder gating the enables.
- Read muxes and bypass logic live in the top.

Test Plan:
1. Assert reset with no clock edges -> ReadRegister1 = 29 gives 32'h7FFF_EFFC; ReadRegister2 = 8 gives 0; reads of 1..31 except 29 give 0.
2. RegWrite = 1, WriteRegister = 8, WriteData = 32'hDEAD_BEEF, one posedge, then RegWrite = 0 -> ReadRegister1 = 8 gives 32'hDEAD_BEEF; ReadRegister2 = 9 gives 0.
3. Write 32'h1234_5678 to register 0 -> ReadData1/2 at index 0 stay 0 before and after the edge.
4. BYPASS = 1: in the same cycle, RegWrite = 1, WriteRegister = ReadRegister2 = 17, WriteData = 32'h0000_00A5 -> ReadData2 = 32'h0000_00A5 before the edge.
   - BYPASS = 0 in the same cycle -> ReadData2 = old value (0) until the edge.
5. Registers 5 = 7 and 6 = 3 written -> ALU with SUB gives ALUResult = 4, Zero = 0; both ports at index 5 give 7 and 7.
6. Reset pulsed asynchronously between edges after writing register 29 = 32'h1000_0000 and register 31 = 32'hFFFF_FFFF -> immediately reg29 = 32'h7FFF_EFFC and reg31 = 0; a write coincident with reset is dropped.
